// File: rtl/incline_led_mon.sv
// incline_led_mon: moving-average incline display with saturated LED window and stale-stream blink.
// Optional INCL_LED_HYST_EN adds display hysteresis of HYST LSBs on normal LED updates.
module incline_led_mon #(
    parameter int DATA_W    = 13,
    parameter int LED_W     = 8,
    parameter int AVG_LOG2  = 2,
    parameter int TIMEOUT   = 50_000_000,
    parameter int BLINK_DIV = 12_500_000,
    parameter int HYST      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld,
    input  logic signed [DATA_W-1:0] incline,
    input  logic [1:0]               shift_sel,
    output logic signed [DATA_W-1:0] avg,
    output logic                     avg_vld,
    output logic                     stale,
    output logic [LED_W-1:0]         LED
);
    localparam int D  = 1 << AVG_LOG2;
    localparam int SW = DATA_W + AVG_LOG2;
    localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int FW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int LMAX = 2 ** (LED_W - 1) - 1;
    localparam int LMIN = -(2 ** (LED_W - 1));

    logic signed [DATA_W-1:0] ring [D];
    logic [PW-1:0]            wptr;
    logic [FW-1:0]            fill, fill_next;
    logic signed [SW-1:0]     sum, sum_next;
    logic [TW-1:0]            tcnt, tcnt_next;
    logic                     stale_next;
    logic [BW-1:0]            bcnt;
    logic signed [DATA_W-1:0] sh;
    logic [LED_W-1:0]         led_new;
    logic                     led_upd;
`ifdef INCL_LED_HYST_EN
    logic signed [DATA_W-1:0] hyst_ref;
    logic                     first;
    int                       dif;
`endif

    always_comb begin
        sum_next   = sum + SW'(incline) - SW'(ring[wptr]);
        fill_next  = (fill == FW'(D)) ? fill : fill + FW'(1);
        tcnt_next  = vld ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
        stale_next = tcnt_next == TW'(TIMEOUT);
        sh         = avg >>> shift_sel;
        led_new    = int'(sh) > LMAX ? {1'b0, {(LED_W-1){1'b1}}} :
                     int'(sh) < LMIN ? {1'b1, {(LED_W-1){1'b0}}} : LED_W'(sh);
`ifdef INCL_LED_HYST_EN
        dif        = int'(avg) - int'(hyst_ref);
        led_upd    = avg_vld && (first || dif > HYST || dif < -HYST);
`else
        led_upd    = avg_vld;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) ring[i] <= '0;
            wptr     <= '0;
            fill     <= '0;
            sum      <= '0;
            avg      <= '0;
            avg_vld  <= 1'b0;
            stale    <= 1'b0;
            LED      <= '0;
            tcnt     <= '0;
            bcnt     <= '0;
`ifdef INCL_LED_HYST_EN
            hyst_ref <= '0;
            first    <= 1'b1;
`endif
        end else begin
            avg_vld <= 1'b0;
            if (vld) begin
                ring[wptr] <= incline;
                wptr       <= (wptr == PW'(D - 1)) ? '0 : wptr + PW'(1);
                fill       <= fill_next;
                sum        <= sum_next;
                avg        <= DATA_W'(sum_next >>> AVG_LOG2);
                avg_vld    <= fill_next == FW'(D);
            end
            tcnt  <= tcnt_next;
            stale <= stale_next;
            // Blink starts at all-ones on entry; on exit the last blink value holds until the next average.
            if (stale_next) begin
                if (!stale) begin
                    LED  <= '1;
                    bcnt <= '0;
                end else if (bcnt == BW'(BLINK_DIV - 1)) begin
                    LED  <= ~LED;
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else if (!stale && led_upd) begin
                LED <= led_new;
`ifdef INCL_LED_HYST_EN
                hyst_ref <= avg;
                first    <= 1'b0;
`endif
            end
`ifdef INCL_LED_HYST_EN
            if (stale && !stale_next) first <= 1'b1;
`endif
        end
    end
endmodule
